// File: rtl/lcd_write_arbiter.sv
// Merges PS2 scan bytes (small FIFO) and processor writes (one-entry slot) into
// round-robin LCD write strobes, each followed by a fixed idle gap.
module lcd_write_arbiter #(
  parameter int unsigned HOLD_CYCLES  = 4,
  parameter int unsigned PS2_DEPTH    = 4,
  parameter bit          FILTER_BREAK = 1'b1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ps2_key_pressed,
  input  logic [7:0]  ps2_out,
  input  logic        proc_write_en,
  input  logic [31:0] proc_write_data,
  output logic        lcd_write_en,
  output logic [7:0]  lcd_write_data,
  output logic        grant_src,
  output logic        proc_busy,
  output logic        ps2_drop,
  output logic        proc_drop
);

  localparam int unsigned   AW         = (PS2_DEPTH > 1) ? $clog2(PS2_DEPTH) : 1;
  localparam int unsigned   CW         = AW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(PS2_DEPTH);
  localparam logic [7:0]    GAP_LAST_C = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0]    BREAK_C    = 8'hF0;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, GAP = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [7:0]    gap_cnt_q, gap_cnt_d;
  logic [7:0]    fifo_q [PS2_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          slot_valid_q, slot_valid_d;
  logic [7:0]    slot_data_q, slot_data_d;
  logic          skip_q, skip_d;
  logic          last_grant_q, last_grant_d;
  logic          lcd_en_q, lcd_en_d;
  logic [7:0]    lcd_data_q, lcd_data_d;
  logic          grant_src_q, grant_src_d;
  logic          proc_busy_q;
  logic          ps2_drop_q, ps2_drop_d, proc_drop_q, proc_drop_d;

  logic issue_s, grant_proc_s, pop_ps2_s, pop_proc_s, pending_s;
  logic push_cand_s, push_acc_s, proc_acc_s;
  logic proc_data_unused_s;

  assign pending_s          = slot_valid_q | (count_q != {CW{1'b0}});
  assign pop_ps2_s          = issue_s & ~grant_proc_s;
  assign pop_proc_s         = issue_s & grant_proc_s;
  assign push_acc_s         = push_cand_s & ((count_q != DEPTH_C) | pop_ps2_s);
  assign proc_acc_s         = proc_write_en & (~slot_valid_q | pop_proc_s);
  assign proc_data_unused_s = ^proc_write_data[31:8];

  // Arbiter FSM: grant decision, write strobe and gap timing
  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    last_grant_d = last_grant_q;
    issue_s      = 1'b0;
    grant_proc_s = 1'b0;
    lcd_en_d     = 1'b0;
    lcd_data_d   = lcd_data_q;
    grant_src_d  = grant_src_q;
    case (state_q)
      IDLE: begin
        if (pending_s) begin
          // Round-robin: with both pending, serve the source not granted last
          state_d      = ISSUE;
          issue_s      = 1'b1;
          grant_proc_s = slot_valid_q & ((count_q == {CW{1'b0}}) | ~last_grant_q);
          last_grant_d = grant_proc_s;
          lcd_en_d     = 1'b1;
          lcd_data_d   = grant_proc_s ? slot_data_q : fifo_q[rd_ptr_q];
          grant_src_d  = grant_proc_s;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d   = GAP;
        gap_cnt_d = 8'd0;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST_C) begin
          state_d   = IDLE;
          gap_cnt_d = 8'd0;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        gap_cnt_d = 8'd0;
      end
    endcase
  end

  // PS2 break filter: 0xF0 arms a skip of the following byte
  always_comb begin
    skip_d      = skip_q;
    push_cand_s = 1'b0;
    if (ps2_key_pressed) begin
      if (FILTER_BREAK && skip_q) begin
        skip_d = 1'b0;
      end else if (FILTER_BREAK && (ps2_out == BREAK_C)) begin
        skip_d = 1'b1;
      end else begin
        push_cand_s = 1'b1;
      end
    end else begin
      skip_d = skip_q;
    end
  end

  // FIFO pointers/count, processor slot and drop pulses
  always_comb begin
    wr_ptr_d     = push_acc_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop_ps2_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d      = count_q;
    slot_valid_d = slot_valid_q;
    slot_data_d  = proc_acc_s ? proc_write_data[7:0] : slot_data_q;
    ps2_drop_d   = push_cand_s & ~push_acc_s;
    proc_drop_d  = proc_write_en & ~proc_acc_s;
    case ({push_acc_s, pop_ps2_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (proc_acc_s) begin
      slot_valid_d = 1'b1;
    end else if (pop_proc_s) begin
      slot_valid_d = 1'b0;
    end else begin
      slot_valid_d = slot_valid_q;
    end
  end

  // FIFO storage
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < PS2_DEPTH; i++) fifo_q[i] <= 8'h00;
    end else if (push_acc_s) begin
      fifo_q[wr_ptr_q] <= ps2_out;
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      gap_cnt_q    <= 8'd0;
      wr_ptr_q     <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      count_q      <= {CW{1'b0}};
      slot_valid_q <= 1'b0;
      slot_data_q  <= 8'h00;
      skip_q       <= 1'b0;
      last_grant_q <= 1'b1;
      lcd_en_q     <= 1'b0;
      lcd_data_q   <= 8'h00;
      grant_src_q  <= 1'b0;
      proc_busy_q  <= 1'b0;
      ps2_drop_q   <= 1'b0;
      proc_drop_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      slot_valid_q <= slot_valid_d;
      slot_data_q  <= slot_data_d;
      skip_q       <= skip_d;
      last_grant_q <= last_grant_d;
      lcd_en_q     <= lcd_en_d;
      lcd_data_q   <= lcd_data_d;
      grant_src_q  <= grant_src_d;
      proc_busy_q  <= slot_valid_d;
      ps2_drop_q   <= ps2_drop_d;
      proc_drop_q  <= proc_drop_d;
    end
  end

  assign lcd_write_en   = lcd_en_q;
  assign lcd_write_data = lcd_data_q;
  assign grant_src      = grant_src_q;
  assign proc_busy      = proc_busy_q;
  assign ps2_drop       = ps2_drop_q;
  assign proc_drop      = proc_drop_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Bench for lcd_write_arbiter: table of single-edge stimuli plus hand-written
// multi-cycle sequences, checked through an expected-write queue.
module tb_lcd_write_arbiter;
  localparam int H  = 4;
  localparam int SP = H + 2;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        ps2_key_pressed = 1'b0;
  logic [7:0]  ps2_out = 8'h00;
  logic        proc_write_en = 1'b0;
  logic [31:0] proc_write_data = 32'h0;
  logic        lcd_write_en, grant_src, proc_busy, ps2_drop, proc_drop;
  logic [7:0]  lcd_write_data;

  lcd_write_arbiter #(.HOLD_CYCLES(H), .PS2_DEPTH(4), .FILTER_BREAK(1'b1)) dut (
    .clock(clock), .resetn(resetn),
    .ps2_key_pressed(ps2_key_pressed), .ps2_out(ps2_out),
    .proc_write_en(proc_write_en), .proc_write_data(proc_write_data),
    .lcd_write_en(lcd_write_en), .lcd_write_data(lcd_write_data),
    .grant_src(grant_src), .proc_busy(proc_busy),
    .ps2_drop(ps2_drop), .proc_drop(proc_drop)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       src;
    int         cyc;
  } exp_t;

  typedef struct {
    bit          ps2_v;
    logic [7:0]  ps2_b;
    bit          proc_v;
    logic [31:0] proc_d;
    int          n_exp;
    logic [7:0]  d0;
    logic        s0;
    logic [7:0]  d1;
    logic        s1;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[8];
  int checks = 0, failures = 0;
  int n_writes = 0, ps2_drops = 0, proc_drops = 0;
  int k, w0, p0, q0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to the next falling edge, score any write, then release the inputs
  task automatic step();
    exp_t e;
    @(negedge clock);
    if (resetn) begin
      if (ps2_drop === 1'b1) ps2_drops++;
      if (proc_drop === 1'b1) proc_drops++;
      if (lcd_write_en === 1'b1) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%0h/src%0b expected=no write (cycle %0d)",
                   lcd_write_data, grant_src, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("wr_data", 32'(lcd_write_data), 32'(e.data));
          chk("wr_src", 32'(grant_src), 32'(e.src));
          chk("wr_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
    ps2_key_pressed = 1'b0;
    proc_write_en   = 1'b0;
  endtask

  task automatic expect_wr(input logic [7:0] d, input logic s, input int c);
    exp_t e;
    e.data = d;
    e.src  = s;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    ps2_key_pressed = 1'b0;
    proc_write_en = 1'b0;
    repeat (3) step();
    resetn = 1'b1;
    w0 = n_writes;
    p0 = ps2_drops;
    q0 = proc_drops;
  endtask

  task automatic ps2(input logic [7:0] b);
    ps2_key_pressed = 1'b1;
    ps2_out = b;
  endtask

  task automatic proc(input logic [31:0] d);
    proc_write_en = 1'b1;
    proc_write_data = d;
  endtask

  task automatic finish_scn(input string name, input int nw, input int npd, input int nqd);
    repeat (30) step();
    chk({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_writes"}, 32'(n_writes - w0), 32'(nw));
    chk({name, "_ps2_drop"}, 32'(ps2_drops - p0), 32'(npd));
    chk({name, "_proc_drop"}, 32'(proc_drops - q0), 32'(nqd));
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h1C, 1'b0, 32'h0,        1, 8'h1C, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 32'h00000041, 1, 8'h41, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 8'h1C, 1'b1, 32'h00000041, 2, 8'h1C, 1'b0, 8'h41, 1'b1};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 32'hDEADBE5A, 1, 8'h5A, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{1'b1, 8'hF0, 1'b0, 32'h0,        0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{1'b1, 8'hF0, 1'b1, 32'h00000033, 1, 8'h33, 1'b1, 8'h00, 1'b0};
    vecs[6] = '{1'b1, 8'h00, 1'b0, 32'h0,        1, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[7] = '{1'b1, 8'hFF, 1'b1, 32'h123456FF, 2, 8'hFF, 1'b0, 8'hFF, 1'b1};

    @(negedge clock);
    chk("rst_en", 32'(lcd_write_en), 32'd0);
    chk("rst_data", 32'(lcd_write_data), 32'd0);
    chk("rst_src", 32'(grant_src), 32'd0);
    chk("rst_busy", 32'(proc_busy), 32'd0);
    chk("rst_ps2_drop", 32'(ps2_drop), 32'd0);
    chk("rst_proc_drop", 32'(proc_drop), 32'd0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      k = cyc + 1;
      ps2_key_pressed = vecs[i].ps2_v;
      ps2_out         = vecs[i].ps2_b;
      proc_write_en   = vecs[i].proc_v;
      proc_write_data = vecs[i].proc_d;
      if (vecs[i].n_exp >= 1) expect_wr(vecs[i].d0, vecs[i].s0, k + 1);
      if (vecs[i].n_exp >= 2) expect_wr(vecs[i].d1, vecs[i].s1, k + 1 + SP);
      step();
      finish_scn($sformatf("vec%0d", i), vecs[i].n_exp, 0, 0);
    end

    // Six PS2 bytes back to back into a depth-4 FIFO: the sixth is lost
    do_reset();
    k = cyc + 1;
    for (int i = 0; i < 6; i++) begin
      ps2(8'h30 + 8'(i));
      if (i < 5) expect_wr(8'h30 + 8'(i), 1'b0, k + 1 + SP * i);
      step();
    end
    finish_scn("overflow", 5, 1, 0);

    // Break sequence is swallowed without a drop pulse
    do_reset();
    k = cyc + 1;
    expect_wr(8'h1C, 1'b0, k + 1);
    expect_wr(8'h32, 1'b0, k + 1 + SP);
    ps2(8'h1C); step();
    ps2(8'hF0); step();
    ps2(8'h1C); step();
    ps2(8'h32); step();
    finish_scn("break", 2, 0, 0);

    // Round-robin flag follows every grant
    do_reset();
    k = cyc + 1;
    expect_wr(8'h01, 1'b0, k + 1);
    expect_wr(8'h02, 1'b1, k + 1 + SP);
    expect_wr(8'h03, 1'b0, k + 1 + 2 * SP);
    ps2(8'h01); proc(32'h00000002); step();
    ps2(8'h03); step();
    finish_scn("rr", 3, 0, 0);

    // Second processor write during GAP hits an occupied slot
    do_reset();
    k = cyc + 1;
    expect_wr(8'h11, 1'b0, k + 1);
    expect_wr(8'h41, 1'b1, k + 1 + SP);
    ps2(8'h11); step();
    step();
    proc(32'h00000041); step();
    chk("slot_busy_load", 32'(proc_busy), 32'd1);
    step();
    proc(32'h00000042); step();
    chk("slot_busy_hold", 32'(proc_busy), 32'd1);
    step(); step();
    chk("slot_busy_pregrant", 32'(proc_busy), 32'd1);
    step();
    chk("slot_busy_grant", 32'(proc_busy), 32'd0);
    finish_scn("slot", 2, 0, 1);

    // Asynchronous reset in GAP with queued work aborts everything
    do_reset();
    k = cyc + 1;
    expect_wr(8'h21, 1'b0, k + 1);
    ps2(8'h21); step();
    ps2(8'h22); proc(32'h00000055); step();
    ps2(8'h23); step();
    step();
    chk("abort_pre_busy", 32'(proc_busy), 32'd1);
    chk("abort_pre_data", 32'(lcd_write_data), 32'h21);
    #2 resetn = 1'b0;
    #1;
    chk("abort_en", 32'(lcd_write_en), 32'd0);
    chk("abort_data", 32'(lcd_write_data), 32'd0);
    chk("abort_busy", 32'(proc_busy), 32'd0);
    chk("abort_src", 32'(grant_src), 32'd0);
    step();
    resetn = 1'b1;
    w0 = n_writes;
    repeat (20) step();
    chk("abort_no_write", 32'(n_writes - w0), 32'd0);
    chk("abort_queue", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lcd_write_arbiter.md
LCD_WRITE_ARBITER -- requirements
Module: lcd_write_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: idle gap cycles after each LCD write strobe (range 1..255).
REQ-002 Parameter PS2_DEPTH, default 4: PS2 byte FIFO depth (power of two, 2..16).
REQ-003 Parameter FILTER_BREAK, default 1: when 1, PS2 break sequences (0xF0 plus the following byte) are discarded.
REQ-004 clock  in  1  single clock; all state on rising edge.
REQ-005 resetn  in  1  reset, asynchronous, active-low.
REQ-006 ps2_key_pressed  in  1  one-cycle strobe; ps2_out valid in the same cycle.
REQ-007 ps2_out  in  8  PS2 scan byte.
REQ-008 proc_write_en  in  1  one-cycle processor write strobe.
REQ-009 proc_write_data  in  32  processor word; only bits [7:0] are forwarded.
REQ-010 lcd_write_en  out  1  one-cycle write strobe to the LCD controller.
REQ-011 lcd_write_data  out  8  character byte, valid while lcd_write_en is high.
REQ-012 grant_src  out  1  source of the current write (0 = PS2, 1 = processor), valid while lcd_write_en is high.
REQ-013 proc_busy  out  1  processor holding slot occupied.
REQ-014 ps2_drop  out  1  one-cycle pulse when a PS2 byte is lost to a full FIFO.
REQ-015 proc_drop  out  1  one-cycle pulse when a processor write is lost to an occupied slot.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 PS2 path: an accepted byte SHALL be pushed into a PS2_DEPTH FIFO on the edge that samples the strobe.
REQ-018 Processor path: an accepted write SHALL load a one-entry slot with bits [7:0]; proc_busy SHALL be high whenever the slot is full.
REQ-019 FSM states: IDLE, ISSUE, GAP.
REQ-020 IDLE with at least one pending source -> ISSUE on the next edge.
  - That edge SHALL pop the granted source and register lcd_write_data and grant_src.
  - lcd_write_en SHALL be high for exactly the one ISSUE cycle.
REQ-021 ISSUE -> GAP unconditionally; GAP SHALL last exactly HOLD_CYCLES cycles, then -> IDLE.
REQ-022 Minimum spacing between consecutive lcd_write_en pulses SHALL be HOLD_CYCLES+2 cycles.
REQ-023 Latency: a strobe sampled at edge k into an empty, IDLE arbiter SHALL give lcd_write_en high between edges k+1 and k+2.
REQ-024 Arbitration SHALL be round-robin on a last_grant flag (reset value 1).
  - If both sources are pending, grant the source not granted last.
  - If only one is pending, grant it.
  - last_grant SHALL update on every grant.
REQ-025 FIFO full: a push SHALL be accepted if a pop occurs on the same edge; otherwise the byte is dropped and ps2_drop pulses.
REQ-026 Slot full: a processor write SHALL be accepted if the slot is granted on the same edge; otherwise it is dropped, proc_drop pulses and the slot contents are unchanged.
REQ-027 FIFO and slot SHALL keep accepting requests during ISSUE and GAP.
REQ-028 Break filter (FILTER_BREAK=1):
  - Byte 0xF0 SHALL set a skip flag and not be pushed.
  - The next PS2 byte SHALL be discarded and clear the flag.
  - Discarded bytes SHALL NOT pulse ps2_drop.
REQ-029 FIFO pointers SHALL wrap modulo PS2_DEPTH; the count SHALL be 0..PS2_DEPTH inclusive.

Reset
REQ-030 resetn low SHALL immediately (asynchronously) force:
  - state IDLE, FIFO empty, slot empty, skip flag clear, GAP counter 0, last_grant 1;
  - lcd_write_en, lcd_write_data, grant_src, proc_busy, ps2_drop, proc_drop all 0.
REQ-031 Reset during ISSUE or GAP SHALL abort the transfer; pending requests are lost and no further strobe is issued.
REQ-032 After resetn rises, the first edge SHALL behave as IDLE with empty queues.

Verification
REQ-033 Single PS2 byte 0x1C, HOLD_CYCLES=4 -> lcd_write_en for one cycle at k+1, lcd_write_data 0x1C, grant_src 0.
REQ-034 PS2 0x1C and processor 0x00000041 strobed on the same edge, after reset -> first write 0x1C (src 0), second write 0x41 (src 1) exactly 6 cycles later.
REQ-035 Six PS2 bytes on consecutive cycles, PS2_DEPTH=4, arbiter IDLE -> bytes 1-5 written in order (the first pop frees a slot); byte 6 raises ps2_drop; no processor activity.
REQ-036 PS2 sequence 0x1C, 0xF0, 0x1C, 0x32 with FILTER_BREAK=1 -> exactly two writes, 0x1C then 0x32; ps2_drop never pulses.
REQ-037 Two processor writes 0x41 and 0x42, 2 cycles apart while GAP is active -> the second raises proc_drop; only 0x41 is written; proc_busy falls on the grant edge.
REQ-038 resetn pulsed low mid-GAP with FIFO holding 2 bytes -> outputs go 0 asynchronously; no lcd_write_en pulse within 20 cycles after release.
